// File: rtl/i2s_rx_dsp_channel.sv
// DSP/PCM-mode I2S receive channel: frame-sync triggered deserialiser for ch0/ch1 into a 2-entry buffer.
// Optional: define I2S_RX_DSP_SIGN_EXT_EN to sign-extend words above bit N-1.

module i2s_rx_dsp_lane #(
  parameter int DATA_W = 32
) (
  input  logic              sck_i,
  input  logic              rstn_i,
  input  logic              keep,
  input  logic              din,
  input  logic [4:0]        idx,
  output logic [DATA_W-1:0] word
);
  logic [DATA_W-1:0] acc;

  // Bits accumulate only while a frame is mid-flight; any other edge wipes the partial word.
  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i)   acc <= '0;
    else if (keep) acc[idx] <= din;
    else           acc <= '0;
  end

  always_comb begin
    word      = acc;
    word[idx] = din;
  end
endmodule

module i2s_rx_dsp_channel #(
  parameter int DATA_W   = 32,
  parameter int OFFSET_W = 9
) (
  input  logic                sck_i,
  input  logic                rstn_i,
  input  logic                i2s_ch0_i,
  input  logic                i2s_ch1_i,
  input  logic                i2s_ws_i,
  output logic [DATA_W-1:0]   fifo_data_o,
  output logic                fifo_data_valid_o,
  input  logic                fifo_data_ready_i,
  output logic                fifo_err_o,
  input  logic                cfg_en_i,
  input  logic                cfg_2ch_i,
  input  logic [4:0]          cfg_num_bits_i,
  input  logic                cfg_lsb_first_i,
  input  logic [OFFSET_W-1:0] cfg_slave_dsp_offset_i
);
  localparam int NUM_LANES = 2;

  typedef enum logic [1:0] {IDLE, WAIT_WS, OFFSET, RUN} state_t;

  state_t                             state, state_nxt, start_st;
  logic [OFFSET_W-1:0]                off_cnt;
  logic [4:0]                         bit_cnt, bit_idx;
  logic                               last, start, smp, keep, done;
  logic [NUM_LANES-1:0][DATA_W-1:0]   lane_word, word_ext;
  logic [1:0][DATA_W-1:0]             buf_q, buf_n;
  logic [1:0]                         cnt, cnt_p, cnt_n;
  logic                               pop, fits, push, err_nxt;

  assign last     = (state == RUN) && (bit_cnt == cfg_num_bits_i);
  // A sync pulse in any framing state (including the last-bit edge) opens a new frame.
  assign start    = cfg_en_i && i2s_ws_i && (state != IDLE);
  assign smp      = cfg_en_i && (state == RUN) && (!i2s_ws_i || last);
  assign keep     = smp && !last;
  assign done     = cfg_en_i && last;
  assign start_st = (cfg_slave_dsp_offset_i != '0) ? OFFSET : RUN;
  assign bit_idx  = cfg_lsb_first_i ? bit_cnt : (cfg_num_bits_i - bit_cnt);

  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!cfg_en_i) state_nxt = IDLE;
    else begin
      unique case (state)
        IDLE:    state_nxt = WAIT_WS;
        WAIT_WS: if (start) state_nxt = start_st;
        OFFSET:  if (start) state_nxt = start_st;
                 else if (off_cnt == '0) state_nxt = RUN;
        RUN:     if (start) state_nxt = start_st;
                 else if (last) state_nxt = WAIT_WS;
      endcase
    end
  end

  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      off_cnt <= '0;
      bit_cnt <= '0;
    end else if (!cfg_en_i) begin
      off_cnt <= '0;
      bit_cnt <= '0;
    end else if (start) begin
      off_cnt <= cfg_slave_dsp_offset_i - OFFSET_W'(1);
      bit_cnt <= '0;
    end else if (state == OFFSET) begin
      off_cnt <= off_cnt - OFFSET_W'(1);
    end else if (keep) begin
      bit_cnt <= bit_cnt + 5'd1;
    end
  end

  i2s_rx_dsp_lane #(.DATA_W(DATA_W)) u_lane [NUM_LANES-1:0] (
    .sck_i  (sck_i),
    .rstn_i (rstn_i),
    .keep   (keep),
    .din    ({i2s_ch1_i, i2s_ch0_i}),
    .idx    (bit_idx),
    .word   (lane_word)
  );

  always_comb begin
    word_ext = lane_word;
`ifdef I2S_RX_DSP_SIGN_EXT_EN
    for (int l = 0; l < NUM_LANES; l++)
      for (int i = 0; i < DATA_W; i++)
        if (i > int'(cfg_num_bits_i)) word_ext[l][i] = lane_word[l][cfg_num_bits_i];
`endif
  end

  // Free space counts a same-cycle pop, so a full buffer being drained still takes a word.
  assign pop     = (cnt != 2'd0) && fifo_data_ready_i;
  assign cnt_p   = cnt - {1'b0, pop};
  assign fits    = cfg_2ch_i ? (cnt_p == 2'd0) : (cnt_p != 2'd2);
  assign push    = done && fits;
  assign err_nxt = done && !fits;

  always_comb begin
    buf_n = buf_q;
    cnt_n = cnt_p;
    if (pop) buf_n[0] = buf_q[1];
    if (push) begin
      if (cnt_p == 2'd0) begin
        buf_n[0] = word_ext[0];
        if (cfg_2ch_i) begin
          buf_n[1] = word_ext[1];
          cnt_n    = 2'd2;
        end else begin
          cnt_n    = 2'd1;
        end
      end else begin
        buf_n[1] = word_ext[0];
        cnt_n    = 2'd2;
      end
    end
  end

  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      buf_q      <= '0;
      cnt        <= '0;
      fifo_err_o <= 1'b0;
    end else if (!cfg_en_i) begin
      buf_q      <= '0;
      cnt        <= '0;
      fifo_err_o <= 1'b0;
    end else begin
      buf_q      <= buf_n;
      cnt        <= cnt_n;
      fifo_err_o <= err_nxt;
    end
  end

  assign fifo_data_o       = buf_q[0];
  assign fifo_data_valid_o = (cnt != 2'd0);
endmodule

// File: tb/tb_i2s_rx_dsp_channel.sv
// Randomised bench for i2s_rx_dsp_channel: frame-level stimulus schedule checked against a queue model.
module tb_i2s_rx_dsp_channel;
  logic        sck = 1'b0, rstn = 1'b0;
  logic        ch0 = 1'b0, ch1 = 1'b0, ws = 1'b0, rdy = 1'b0, en = 1'b0;
  logic        two = 1'b0, lsb = 1'b0;
  logic [4:0]  nb = 5'd15;
  logic [8:0]  off = 9'd0;
  logic [31:0] data;
  logic        valid, err;

  i2s_rx_dsp_channel dut (
    .sck_i(sck), .rstn_i(rstn), .i2s_ch0_i(ch0), .i2s_ch1_i(ch1), .i2s_ws_i(ws),
    .fifo_data_o(data), .fifo_data_valid_o(valid), .fifo_data_ready_i(rdy), .fifo_err_o(err),
    .cfg_en_i(en), .cfg_2ch_i(two), .cfg_num_bits_i(nb), .cfg_lsb_first_i(lsb),
    .cfg_slave_dsp_offset_i(off)
  );

  always #5 sck = ~sck;

  typedef struct {
    logic        ws, c0, c1, en, rdy, done;
    logic [31:0] w0, w1;
  } cyc_t;

  cyc_t        st [0:8191];
  int          len = 0;
  int          rdy_mode = 1;
  int          n_chk = 0, n_pass = 0;
  logic [31:0] q[$];
  logic        err_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic rdy_bit();
    if (rdy_mode == 0) return 1'b0;
    if (rdy_mode == 1) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic put(input logic w, input logic a, input logic b, input logic e,
                     input logic dn, input logic [31:0] x, input logic [31:0] y);
    st[len] = '{ws: w, c0: a, c1: b, en: e, rdy: rdy_bit(), done: dn, w0: x, w1: y};
    len++;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) put(1'b0, 1'($urandom), 1'($urandom), 1'b1, 1'b0, '0, '0);
  endtask

  task automatic scn_begin();
    put(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    gap(1);
  endtask

  // Expected received word: low N bits of the sent value, upper bits zero or sign copies.
  function automatic logic [31:0] exp_word(input logic [31:0] w);
    int n = int'(nb) + 1;
    logic [31:0] m, r;
    m = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    r = w & m;
`ifdef I2S_RX_DSP_SIGN_EXT_EN
    if (r[n-1]) r = r | ~m;
`endif
    return r;
  endfunction

  // One frame: sync cycle (or shared with the previous last bit), offset cycles, N bits.
  task automatic frame(input logic [31:0] a, input logic [31:0] b, input bit shared);
    int n = int'(nb) + 1;
    int k;
    if (shared) st[len-1].ws = 1'b1;
    else put(1'b1, 1'($urandom), 1'($urandom), 1'b1, 1'b0, '0, '0);
    gap(int'(off));
    for (int j = 0; j < n; j++) begin
      k = lsb ? j : n - 1 - j;
      put(1'b0, a[k], b[k], 1'b1, j == n - 1, exp_word(a), exp_word(b));
    end
  endtask

  // Sync followed by fewer cycles than a full frame; the next sync resyncs it.
  task automatic partial(input int l);
    put(1'b1, 1'($urandom), 1'($urandom), 1'b1, 1'b0, '0, '0);
    gap(l);
  endtask

  task automatic run();
    for (int c = 0; c < len; c++) begin
      ws = st[c].ws; ch0 = st[c].c0; ch1 = st[c].c1; en = st[c].en; rdy = st[c].rdy;
      @(posedge sck);
      err_exp = 1'b0;
      if (!st[c].en) q.delete();
      else begin
        if (q.size() > 0 && st[c].rdy) void'(q.pop_front());
        if (st[c].done) begin
          if (q.size() + (two ? 2 : 1) <= 2) begin
            q.push_back(st[c].w0);
            if (two) q.push_back(st[c].w1);
          end else err_exp = 1'b1;
        end
      end
      @(negedge sck);
      chk("valid", 32'(valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("data", data, q[0]);
      chk("err", 32'(err), 32'(err_exp));
    end
    len = 0;
  endtask

  task automatic cfg(input int n, input int o, input bit t, input bit l, input int rm);
    nb = 5'(n - 1); off = 9'(o); two = t; lsb = l; rdy_mode = rm;
  endtask

  initial begin
    bit prev_done;
    #12;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge sck);
    rstn = 1'b1;

    // 16-bit MSB-first, offset 0, single channel
    cfg(16, 0, 0, 0, 1); scn_begin(); frame(32'h0000A5C3, 0, 0); gap(3); run();
    // 24-bit LSB-first, offset 3, two channels
    cfg(24, 3, 1, 1, 1); scn_begin(); frame(32'h00123456, 32'h00ABCDEF, 0); gap(4); run();
    // back-pressure: first frame held, next two dropped
    cfg(16, 1, 1, 0, 0); scn_begin();
    frame(32'h1111, 32'h2222, 0); gap(2); frame(32'h3333, 32'h4444, 0); gap(2);
    frame(32'h5555, 32'h6666, 0); rdy_mode = 1; gap(5); run();
    // resync at bit 7
    cfg(16, 0, 0, 0, 1); scn_begin(); partial(7); frame(32'hBEEF, 0, 0); gap(3); run();
    // disable mid-word with a word buffered, then re-enable
    cfg(16, 2, 0, 1, 0); scn_begin(); frame(32'hCAFE, 0, 0); partial(8);
    put(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0); gap(1);
    rdy_mode = 1; frame(32'h7E57, 0, 0); gap(3); run();
    // 8-bit word with top bit set
    cfg(8, 0, 0, 0, 1); scn_begin(); frame(32'h9C, 0, 0); gap(3); run();

    // randomised configurations and frame sequences
    for (int s = 0; s < 12; s++) begin
      cfg($urandom_range(1, 32), ($urandom_range(0, 3) == 0) ? $urandom_range(6, 40) : $urandom_range(0, 5),
          1'($urandom), 1'($urandom), 2);
      scn_begin(); prev_done = 0;
      for (int f = 0; f < 8; f++) begin
        int r = $urandom_range(0, 9);
        if (r < 2) begin
          partial($urandom_range(0, int'(off) + int'(nb)));
          frame($urandom, $urandom, 0);
        end else if (r < 5 && prev_done) begin
          frame($urandom, $urandom, 1);
        end else begin
          gap($urandom_range(0, 3));
          frame($urandom, $urandom, 0);
        end
        prev_done = 1;
      end
      rdy_mode = 1; gap(5); run();
    end

    // asynchronous reset in the middle of a word, with a word buffered
    cfg(16, 0, 0, 0, 0); scn_begin(); frame(32'h1234, 0, 0); partial(5); run();
    #2 rstn = 1'b0;
    #1;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_data", data, 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    q.delete();
    #1 rstn = 1'b1;
    @(negedge sck);
    cfg(16, 0, 0, 0, 1); scn_begin(); frame(32'h4321, 0, 0); gap(3); run();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
